// File: rtl/life_pkg.sv
// Shared types and sizing for the Game of Life grid engine.
package life_pkg;

  localparam int GRID_W_DEF = 80;
  localparam int GRID_H_DEF = 60;
  localparam int CELLS      = GRID_W_DEF * GRID_H_DEF;
  localparam int ADDR_W     = 13;
  localparam int X_W        = 7;
  localparam int Y_W        = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPUTE   = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

endpackage

// File: rtl/life_rule.sv
// Conway rule for a single cell: neighbour population count and next state.
module life_rule (
  input  logic [7:0] nbr_i,
  input  logic       cur_i,
  output logic [3:0] count_o,
  output logic       next_o
);

  // Sum the eight neighbours, then apply birth on 3 / survival on 2 or 3.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'b000, nbr_i[i]};
    end
    next_o = (count_o == 4'd3) | (cur_i & (count_o == 4'd2));
  end

endmodule

// File: rtl/life_grid_engine.sv
// Double-buffered Game of Life grid: renderer lookups, cursor edits, and one
// generation per step computed into the shadow bank, swapped at frame start.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF,
  parameter int WRAP   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [X_W-1:0] render_x,
  input  logic [Y_W-1:0] render_y,
  output logic           render_cell,
  input  logic [X_W-1:0] cursor_x,
  input  logic [Y_W-1:0] cursor_y,
  input  logic           toggle_req,
  input  logic           clear_req,
  input  logic           step_req,
  input  logic           frame_start,
  output logic           busy,
  output logic [15:0]    gen_count
);

  localparam int             NCELL = GRID_W * GRID_H;
  localparam logic [X_W-1:0] X_MAX = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GRID_H - 1);

  state_t           state_q, state_d;
  logic             bank_sel_q, bank_sel_d;
  logic [15:0]      gen_q, gen_d;
  logic [X_W-1:0]   sx_q, sx_d;
  logic [Y_W-1:0]   sy_q, sy_d;
  logic             busy_q;
  logic [NCELL-1:0] bank0_q, bank0_d;
  logic [NCELL-1:0] bank1_q, bank1_d;

  logic [NCELL-1:0] disp;
  logic [X_W-1:0]   xl, xr;
  logic [Y_W-1:0]   yu, yd;
  logic             xl_ok, xr_ok, yu_ok, yd_ok;
  logic [7:0]       nbr;
  logic             cur_bit;
  logic             rule_next;
  // Count is exposed by the rule block for standalone testing; the engine only
  // consumes the next-state bit.
  logic [3:0]       rule_count_unused;
  logic [ADDR_W-1:0] scan_addr, cur_addr;
  logic             cursor_ok, render_ok;

  function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                 input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
  endfunction

  // Displayed bank view, renderer lookup and neighbour fetch around the scan cell.
  always_comb begin
    disp      = bank_sel_q ? bank1_q : bank0_q;
    render_ok = (int'(render_x) < GRID_W) && (int'(render_y) < GRID_H);
    render_cell = render_ok & disp[lin_addr(render_x, render_y)];

    xl    = (sx_q == '0)    ? X_MAX : sx_q - X_W'(1);
    xr    = (sx_q == X_MAX) ? '0    : sx_q + X_W'(1);
    yu    = (sy_q == '0)    ? Y_MAX : sy_q - Y_W'(1);
    yd    = (sy_q == Y_MAX) ? '0    : sy_q + Y_W'(1);
    xl_ok = (sx_q != '0)    || (WRAP != 0);
    xr_ok = (sx_q != X_MAX) || (WRAP != 0);
    yu_ok = (sy_q != '0)    || (WRAP != 0);
    yd_ok = (sy_q != Y_MAX) || (WRAP != 0);

    nbr[0] = disp[lin_addr(xl,   yu  )] & xl_ok & yu_ok;
    nbr[1] = disp[lin_addr(sx_q, yu  )] & yu_ok;
    nbr[2] = disp[lin_addr(xr,   yu  )] & xr_ok & yu_ok;
    nbr[3] = disp[lin_addr(xl,   sy_q)] & xl_ok;
    nbr[4] = disp[lin_addr(xr,   sy_q)] & xr_ok;
    nbr[5] = disp[lin_addr(xl,   yd  )] & xl_ok & yd_ok;
    nbr[6] = disp[lin_addr(sx_q, yd  )] & yd_ok;
    nbr[7] = disp[lin_addr(xr,   yd  )] & xr_ok & yd_ok;

    scan_addr = lin_addr(sx_q, sy_q);
    cur_bit   = disp[scan_addr];
    cur_addr  = lin_addr(cursor_x, cursor_y);
    cursor_ok = (int'(cursor_x) < GRID_W) && (int'(cursor_y) < GRID_H);
  end

  life_rule u_rule (
    .nbr_i   (nbr),
    .cur_i   (cur_bit),
    .count_o (rule_count_unused),
    .next_o  (rule_next)
  );

  // Next-state logic: edits in IDLE, row-major scan in COMPUTE, swap in WAIT_SWAP.
  always_comb begin
    state_d    = state_q;
    bank_sel_d = bank_sel_q;
    gen_d      = gen_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    bank0_d    = bank0_q;
    bank1_d    = bank1_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          if (bank_sel_q) bank1_d = '0;
          else            bank0_d = '0;
        end else if (toggle_req) begin
          if (cursor_ok) begin
            if (bank_sel_q) bank1_d[cur_addr] = ~bank1_q[cur_addr];
            else            bank0_d[cur_addr] = ~bank0_q[cur_addr];
          end
        end else if (step_req) begin
          sx_d    = '0;
          sy_d    = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        // The shadow bank is the one not on display.
        if (bank_sel_q) bank0_d[scan_addr] = rule_next;
        else            bank1_d[scan_addr] = rule_next;
        if (sx_q == X_MAX) begin
          sx_d = '0;
          if (sy_q == Y_MAX) begin
            sy_d    = '0;
            state_d = WAIT_SWAP;
          end else begin
            sy_d = sy_q + Y_W'(1);
          end
        end else begin
          sx_d = sx_q + X_W'(1);
        end
      end
      WAIT_SWAP: begin
        if (frame_start) begin
          bank_sel_d = ~bank_sel_q;
          gen_d      = gen_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, banks and counters; reset clears everything and aborts any generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bank_sel_q <= 1'b0;
      gen_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      busy_q     <= 1'b0;
      bank0_q    <= '0;
      bank1_q    <= '0;
    end else begin
      state_q    <= state_d;
      bank_sel_q <= bank_sel_d;
      gen_q      <= gen_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      busy_q     <= (state_d != IDLE);
      bank0_q    <= bank0_d;
      bank1_q    <= bank1_d;
    end
  end

  assign busy      = busy_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine: a toroidal and a bounded instance
// share stimulus and are compared against a bench-side Life model.
module tb_life_grid_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] render_x, cursor_x;
  logic [5:0] render_y, cursor_y;
  logic       toggle_req, clear_req, step_req, frame_start;
  logic       cell_w1, cell_w0, busy_w1, busy_w0;
  logic [15:0] gen_w1, gen_w0;

  int n_cmp = 0;
  int n_err = 0;
  int exp_gen = 0;
  bit mdl [2][60][80];  // index 0: bounded instance, 1: toroidal instance
  logic exp_q[$];

  always #5 clk = ~clk;

  life_grid_engine #(.GRID_W(80), .GRID_H(60), .WRAP(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .render_x(render_x), .render_y(render_y),
    .render_cell(cell_w1), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .toggle_req(toggle_req), .clear_req(clear_req), .step_req(step_req),
    .frame_start(frame_start), .busy(busy_w1), .gen_count(gen_w1)
  );

  life_grid_engine #(.GRID_W(80), .GRID_H(60), .WRAP(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n), .render_x(render_x), .render_y(render_y),
    .render_cell(cell_w0), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .toggle_req(toggle_req), .clear_req(clear_req), .step_req(step_req),
    .frame_start(frame_start), .busy(busy_w0), .gen_count(gen_w0)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic probe(input int inst, input int x, input int y, input logic exp, input string tag);
    exp_q.push_back(exp);
    render_x = 7'(x);
    render_y = 6'(y);
    #1;
    check_val($sformatf("%s(%0d,%0d)w%0d", tag, x, y, inst),
              (inst != 0) ? cell_w1 : cell_w0, exp_q.pop_front());
  endtask

  task automatic check_grid(input string tag);
    for (int inst = 0; inst < 2; inst++)
      for (int y = 0; y < 60; y++)
        for (int x = 0; x < 80; x++)
          probe(inst, x, y, mdl[inst][y][x], tag);
  endtask

  task automatic check_ctrl(input string tag, input logic exp_busy);
    check_val({tag, "_busy_w1"}, busy_w1, exp_busy);
    check_val({tag, "_busy_w0"}, busy_w0, exp_busy);
    check_val({tag, "_gen_w1"}, gen_w1, exp_gen);
    check_val({tag, "_gen_w0"}, gen_w0, exp_gen);
  endtask

  function automatic void mdl_clear();
    for (int i = 0; i < 2; i++)
      for (int y = 0; y < 60; y++)
        for (int x = 0; x < 80; x++)
          mdl[i][y][x] = 1'b0;
  endfunction

  function automatic void mdl_step();
    bit nx [2][60][80];
    for (int i = 0; i < 2; i++)
      for (int y = 0; y < 60; y++)
        for (int x = 0; x < 80; x++) begin
          int n = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++) begin
              int xx = x + dx;
              int yy = y + dy;
              if (dx == 0 && dy == 0) continue;
              if (i == 1) begin
                xx = (xx + 80) % 80;
                yy = (yy + 60) % 60;
              end else if (xx < 0 || xx > 79 || yy < 0 || yy > 59) begin
                continue;
              end
              n += int'(mdl[i][yy][xx]);
            end
          nx[i][y][x] = (n == 3) || (mdl[i][y][x] && n == 2);
        end
    mdl = nx;
  endfunction

  task automatic do_toggle(input int x, input int y, input bit apply);
    @(negedge clk);
    cursor_x = 7'(x); cursor_y = 6'(y); toggle_req = 1'b1;
    @(negedge clk);
    toggle_req = 1'b0;
    if (apply && x < 80 && y < 60) begin
      mdl[0][y][x] = !mdl[0][y][x];
      mdl[1][y][x] = !mdl[1][y][x];
    end
  endtask

  task automatic do_step();
    @(negedge clk);
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
  endtask

  // Step, then frame_start on the edge entering WAIT_SWAP (ignored) and the next one (swap).
  task automatic run_gen(input string tag);
    do_step();
    check_ctrl({tag, "_start"}, 1'b1);
    repeat (4799) @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    check_ctrl({tag, "_fs_on_entry"}, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    exp_gen++;
    mdl_step();
    check_ctrl({tag, "_swapped"}, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    render_x = '0; render_y = '0; cursor_x = '0; cursor_y = '0;
    toggle_req = 1'b0; clear_req = 1'b0; step_req = 1'b0; frame_start = 1'b0;
    mdl_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and single-cell toggles.
    check_ctrl("reset", 1'b0);
    probe(1, 5, 5, 1'b0, "reset");
    probe(0, 79, 59, 1'b0, "reset");
    do_toggle(5, 5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      probe(i, 5, 5, 1'b1, "tog1");
      probe(i, 4, 5, 1'b0, "tog1");
      probe(i, 6, 5, 1'b0, "tog1");
    end
    do_toggle(5, 5, 1'b1);
    probe(1, 5, 5, 1'b0, "tog2");
    probe(0, 5, 5, 1'b0, "tog2");
    check_ctrl("tog2", 1'b0);

    // Blinker with a long WAIT_SWAP and dropped requests throughout.
    do_toggle(10, 9, 1'b1);
    do_toggle(10, 10, 1'b1);
    do_toggle(10, 11, 1'b1);
    do_step();
    check_ctrl("blink_start", 1'b1);
    for (int c = 1; c < 4800; c++) begin
      if (c == 2000) begin
        probe(1, 10, 9, 1'b1, "compute_old");
        probe(1, 9, 10, 1'b0, "compute_old");
        check_ctrl("compute_mid", 1'b1);
      end
      if (c == 3000) begin cursor_x = 7'd10; cursor_y = 6'd10; toggle_req = 1'b1; end
      if (c == 3001) toggle_req = 1'b0;
      if (c == 3100) step_req = 1'b1;
      if (c == 3101) step_req = 1'b0;
      @(negedge clk);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check_ctrl("fs_on_entry", 1'b1);
    for (int c = 0; c < 10000; c++) begin
      if (c == 100) begin cursor_x = 7'd10; cursor_y = 6'd10; toggle_req = 1'b1; end
      if (c == 101) toggle_req = 1'b0;
      if (c == 200) step_req = 1'b1;
      if (c == 201) step_req = 1'b0;
      if (c == 300) clear_req = 1'b1;
      if (c == 301) clear_req = 1'b0;
      if (c % 2500 == 2499) begin
        probe(1, 10, 9, 1'b1, "wait_old");
        probe(0, 10, 11, 1'b1, "wait_old");
        check_ctrl("wait", 1'b1);
      end
      @(negedge clk);
    end
    check_grid("wait_grid");
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    exp_gen++;
    mdl_step();
    check_ctrl("blink_swap", 1'b0);
    probe(1, 9, 10, 1'b1, "blink");
    probe(1, 11, 10, 1'b1, "blink");
    probe(1, 10, 9, 1'b0, "blink");
    check_grid("blink_grid");
    repeat (20) @(negedge clk);
    check_ctrl("no_extra_gen", 1'b0);

    // Edge column: wrap vs. bounded.
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    mdl_clear();
    do_toggle(0, 9, 1'b1);
    do_toggle(0, 10, 1'b1);
    do_toggle(0, 11, 1'b1);
    run_gen("edge");
    probe(1, 79, 10, 1'b1, "edge");
    probe(1, 0, 10, 1'b1, "edge");
    probe(1, 1, 10, 1'b1, "edge");
    probe(1, 0, 9, 1'b0, "edge");
    probe(0, 79, 10, 1'b0, "edge");
    probe(0, 0, 10, 1'b1, "edge");
    probe(0, 1, 10, 1'b1, "edge");
    check_grid("edge_grid");

    // Priority and out-of-range handling.
    do_toggle(0, 1, 1'b1);
    @(negedge clk);
    clear_req = 1'b1; toggle_req = 1'b1; cursor_x = 7'd3; cursor_y = 6'd3;
    @(negedge clk);
    clear_req = 1'b0; toggle_req = 1'b0;
    mdl_clear();
    probe(1, 3, 3, 1'b0, "clr_tog");
    probe(1, 0, 1, 1'b0, "clr_tog");
    probe(0, 0, 10, 1'b0, "clr_tog");
    do_toggle(0, 1, 1'b1);
    do_toggle(80, 0, 1'b0);
    do_toggle(0, 60, 1'b0);
    probe(1, 0, 1, 1'b1, "oor_cursor");
    probe(0, 0, 1, 1'b1, "oor_cursor");
    probe(1, 80, 0, 1'b0, "oor_render");
    probe(1, 0, 60, 1'b0, "oor_render");
    probe(0, 80, 0, 1'b0, "oor_render");
    @(negedge clk);
    toggle_req = 1'b1; step_req = 1'b1; cursor_x = 7'd2; cursor_y = 6'd2;
    @(negedge clk);
    toggle_req = 1'b0; step_req = 1'b0;
    mdl[0][2][2] = 1'b1; mdl[1][2][2] = 1'b1;
    check_ctrl("tog_over_step", 1'b0);
    probe(1, 2, 2, 1'b1, "tog_over_step");

    // Reset in the middle of COMPUTE.
    do_step();
    repeat (2000) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_gen = 0;
    mdl_clear();
    #1;
    check_ctrl("mid_rst", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    check_grid("after_rst");
    do_toggle(10, 9, 1'b1);
    do_toggle(10, 10, 1'b1);
    do_toggle(10, 11, 1'b1);
    run_gen("post_rst");
    probe(1, 9, 10, 1'b1, "post_rst");
    probe(1, 10, 9, 1'b0, "post_rst");
    check_grid("post_rst_grid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
Owns the 80x60 Game of Life cell state and answers the renderer's per-pixel cell lookups (grid coordinate in, cell bit out). It applies cursor edits (toggle/clear) and computes one generation per step request into a shadow bank. The banks are swapped only at a frame boundary, so the display never shows a half-updated generation. It sits between the input/cursor controller, the VGA timing block (frame_start) and the grid renderer.

Parameters:
GRID_W, 80, columns; x coordinate 0..GRID_W-1
GRID_H, 60, rows; y coordinate 0..GRID_H-1
WRAP, 1, 1 = toroidal edges; 0 = cells outside the grid count as dead

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
render_x  in  7  column requested by the renderer
render_y  in  6  row requested by the renderer
render_cell  out  1  state of (render_x, render_y) in the displayed bank
cursor_x  in  7  edit column
cursor_y  in  6  edit row
toggle_req  in  1  single-cycle pulse: invert the cell at the cursor
clear_req  in  1  single-cycle pulse: kill every cell in the displayed bank
step_req  in  1  single-cycle pulse: compute the next generation
frame_start  in  1  single-cycle pulse at the start of vertical blank
busy  out  1  high while a generation is computing or awaiting its swap
gen_count  out  16  number of generations swapped in since reset

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Storage: two banks of GRID_W*GRID_H bits. Linear address = y*GRID_W + x (13 bits). bank_sel selects the displayed bank.
- Reset: both banks all zero; bank_sel=0; state=IDLE; busy=0; gen_count=0; scan counters=0. Reset during COMPUTE or WAIT_SWAP aborts the generation, and the engine comes up with the same values.
- render_cell: combinational read of the displayed bank, zero latency. If render_x>=GRID_W or render_y>=GRID_H, render_cell=0.
- FSM states: IDLE, COMPUTE, WAIT_SWAP.
- IDLE: requests sampled on clk are handled in priority order clear_req > toggle_req > step_req. Only the highest-priority request is taken; the others in that cycle are dropped.
  - clear_req: all displayed-bank bits become 0 on that edge.
  - toggle_req: displayed-bank bit at the cursor is inverted on that edge. An out-of-range cursor is a no-op.
  - step_req: scan x,y reset to 0,0; go to COMPUTE; busy=1 from the next cycle.
- COMPUTE: one cell per cycle in row-major order.
  - For cell (x,y), n = count of the 8 neighbours in the displayed bank (4-bit).
  - WRAP=1: x-1 at x=0 is GRID_W-1; x+1 at GRID_W-1 is 0; rows wrap the same way. WRAP=0: out-of-grid neighbours read as 0.
  - next = (n==3) | (cur & n==2), written to the shadow bank at (x,y).
  - After cell (GRID_W-1, GRID_H-1), go to WAIT_SWAP. COMPUTE lasts exactly GRID_W*GRID_H = 4800 cycles.
  - The displayed bank is never written during COMPUTE, so render reads return the old generation.
- WAIT_SWAP: hold until frame_start is sampled high. On that edge: bank_sel toggles, gen_count increments (65535 wraps to 0), state becomes IDLE, busy=0 from the next cycle.
- frame_start in IDLE or COMPUTE is ignored. A frame_start on the same edge that enters WAIT_SWAP is not used; the engine waits for the next pulse.
- toggle_req, clear_req and step_req are ignored, not queued, while busy or in WAIT_SWAP.
- busy is registered: 1 in COMPUTE and WAIT_SWAP, 0 otherwise.

Decomposition:
- Package life_pkg: GRID_W/GRID_H defaults, CELLS=4800, ADDR_W=13, coordinate widths 7/6, enum state_t {IDLE, COMPUTE, WAIT_SWAP}.
- Sub-module life_rule (combinational): inputs are the 8 neighbour bits and the current bit; outputs are the 4-bit count and the next-state bit. Unit-testable on its own.
- Bank storage, address math, wrap handling and the FSM live in life_grid_engine.

Test Plan:
1. Reset; toggle (5,5) -> render(5,5)=1, render(4,5)=0, render(6,5)=0; toggle (5,5) again -> 0; gen_count=0, busy=0.
2. Cells (10,9),(10,10),(10,11) alive; step_req -> busy=1 for exactly 4800 cycles, then WAIT_SWAP; pulse frame_start -> (9,10),(10,10),(11,10) alive, (10,9)=0, gen_count=1, busy=0.
3. WRAP=1, cells (0,9),(0,10),(0,11) alive; step + frame_start -> (79,10),(0,10),(1,10) alive. With WRAP=0 -> only (0,10),(1,10) alive.
4. No tearing: during COMPUTE and for 10000 cycles in WAIT_SWAP with frame_start low, every render read returns generation 0; busy stays 1 and gen_count stays 0.
5. Drops and priority: toggle_req/step_req while busy -> grid unchanged after swap and only one generation added. clear_req with toggle_req in the same IDLE cycle -> all cells 0. render (80,0) or (0,60) -> 0.
6. Assert rst_n low at cycle 2000 of COMPUTE -> busy=0, gen_count=0, all render reads 0 in both banks, state IDLE; a later step behaves as in scenario 2.
